reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning architectural register count (power of two, >=2); AW = clog2(NUM_REGS).
REQ-003 The block SHALL have parameter RD_PORTS, default 2, meaning number of independent read ports (1..4).
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning that 1 forwards same-cycle writeback data to read ports and 0 disables forwarding.
REQ-005 The block SHALL have port clk  in  1  -- the single clock, with all state updated on its rising edge.
REQ-006 The block SHALL have port rst_n  in  1  -- a synchronous, active-low reset.
REQ-007 The block SHALL have port rd_addr  in  RD_PORTS*AW  -- read addresses, with port i occupying bits [i*AW +: AW].
REQ-008 The block SHALL have port rd_data  out  RD_PORTS*XLEN  -- combinational read data per port.
REQ-009 The block SHALL have port rd_busy  out  RD_PORTS  -- per-port flag meaning the addressed register has a pending writeback (RAW hazard).
REQ-010 The block SHALL have port iss_vld  in  1  -- an instruction issuing with a destination register this cycle.
REQ-011 The block SHALL have port iss_addr  in  AW  -- destination register reserved at issue.
REQ-012 The block SHALL have port wb_vld  in  1  -- a writeback valid this cycle.
REQ-013 The block SHALL have port wb_addr  in  AW  -- writeback destination register.
REQ-014 The block SHALL have port wb_data  in  XLEN  -- writeback data, already selected between ALU and DM results upstream.
REQ-015 The block SHALL have port iss_waw  out  1  -- combinational flag for a WAW reservation: issue to a register that is already pending.
REQ-016 The block SHALL have port wb_orphan  out  1  -- combinational flag for a writeback to a non-pending register.
REQ-017 The block SHALL have port pend_cnt  out  clog2(NUM_REGS+1)  -- registered count of pending registers.

Function
REQ-018 Register 0 SHALL always read zero; writes to it SHALL be discarded; it SHALL never become pending; iss_waw and wb_orphan SHALL never assert for address 0.
REQ-019 On a clock edge with wb_vld=1 and wb_addr!=0, regs[wb_addr] SHALL take wb_data.
REQ-020 rd_data[i] SHALL be regs[rd_addr[i]] with zero-cycle latency.
REQ-021 When BYPASS=1, wb_vld=1 and wb_addr==rd_addr[i]!=0, rd_data[i] SHALL be wb_data instead of the stored value.
REQ-022 rd_busy[i] SHALL equal pending[rd_addr[i]], except that it SHALL be 0 when BYPASS=1, wb_vld=1 and wb_addr==rd_addr[i].
REQ-023 On a clock edge with iss_vld=1 and iss_addr!=0, pending[iss_addr] SHALL be set.
REQ-024 On a clock edge with wb_vld=1, pending[wb_addr] SHALL be cleared.
REQ-025 When an issue and a writeback occur on the same address in the same edge, pending SHALL remain set (the issue wins) and the data SHALL still be written.
REQ-026 When an issue and a writeback occur on different addresses in the same edge, both pending updates SHALL apply.
REQ-027 iss_waw SHALL equal iss_vld & pending[iss_addr] & ~(wb_vld & wb_addr==iss_addr); a WAW issue SHALL leave the pending bit set and SHALL NOT change pend_cnt.
REQ-028 wb_orphan SHALL equal wb_vld & (wb_addr!=0) & ~pending[wb_addr]; an orphan writeback SHALL still write the data.
REQ-029 pend_cnt SHALL track the population count of the pending bits: +1 for a new set, -1 for a real clear, net 0 for simultaneous set and clear or for a same-address issue and writeback.
REQ-030 pend_cnt SHALL never wrap; its maximum value is NUM_REGS-1.

Reset
REQ-031 While rst_n=0 at a clock edge, all registers SHALL clear to 0, all pending bits SHALL clear, and pend_cnt SHALL become 0; iss_vld and wb_vld SHALL be ignored in that cycle.
REQ-032 Reset asserted mid-operation SHALL discard outstanding reservations; writebacks arriving after reset SHALL be flagged wb_orphan and SHALL still write.
REQ-033 Combinational outputs SHALL reflect the cleared state in the cycle after the reset edge: rd_data=0, rd_busy=0, pend_cnt=0.

Verification
REQ-034 Write then read: wb x5=0xDEADBEEF with no issue -> wb_orphan=1 that cycle; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF, rd_busy0=0.
REQ-035 RAW hazard and bypass: issue x3, then hold rd_addr1=3 -> rd_busy1=1 and pend_cnt=1; then wb x3=0x12 -> with BYPASS=1, same cycle rd_data1=0x12 and rd_busy1=0; with BYPASS=0, rd_busy1=1 and rd_data1=old value; next cycle pend_cnt=0.
REQ-036 Same-address issue and writeback: x7 pending, issue x7 and wb x7=0x55 in one cycle -> iss_waw=0, next cycle pending[7]=1, regs[7]=0x55, pend_cnt=1.
REQ-037 x0: wb x0=0xFFFF and issue x0 -> rd_data=0, rd_busy=0, pend_cnt unchanged, iss_waw=0, wb_orphan=0.
REQ-038 Count and WAW: issue x1..x31 on consecutive cycles -> pend_cnt=31; reissue x4 -> iss_waw=1 and pend_cnt=31.
REQ-039 Reset mid-operation: then assert rst_n=0 for one edge -> pend_cnt=0, all rd_data=0; a following wb x4 -> wb_orphan=1.

Source files
------------

// File: rtl/reg_file_sb.sv
// Architectural register file with a pending-writeback scoreboard, optional
// same-cycle writeback forwarding and hazard flags for issue/writeback.
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int RD_PORTS = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int CW      = $clog2(NUM_REGS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RD_PORTS*AW-1:0]   rd_addr,
    output logic [RD_PORTS*XLEN-1:0] rd_data,
    output logic [RD_PORTS-1:0]      rd_busy,
    input  logic                     iss_vld,
    input  logic [AW-1:0]            iss_addr,
    input  logic                     wb_vld,
    input  logic [AW-1:0]            wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     iss_waw,
    output logic                     wb_orphan,
    output logic [CW-1:0]            pend_cnt
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pend_next;
    logic [CW-1:0]       cnt;

    logic wb_write;
    logic iss_set;
    logic same_addr;
    logic cnt_inc;
    logic cnt_dec;

    assign wb_write  = wb_vld && (wb_addr != '0);
    assign iss_set   = iss_vld && (iss_addr != '0);
    assign same_addr = iss_set && wb_vld && (wb_addr == iss_addr);

    // The counter follows the popcount of the pending vector: a set only
    // counts if the bit was clear, a clear only counts if the issue on the
    // same address does not immediately re-reserve it.
    assign cnt_inc = iss_set && !pending[iss_addr];
    assign cnt_dec = wb_vld && pending[wb_addr] && !same_addr;

    always_comb begin
        pend_next = pending;
        if (wb_vld)
            pend_next[wb_addr] = 1'b0;
        if (iss_set)
            pend_next[iss_addr] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            cnt     <= '0;
        end else begin
            pending <= pend_next;
            cnt     <= cnt + CW'(cnt_inc) - CW'(cnt_dec);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Forwarding makes a same-cycle writeback look already retired to readers.
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = rd_addr[p*AW +: AW];
        assign hit  = (BYPASS != 0) && wb_vld && (wb_addr == addr);

        assign rd_data[p*XLEN +: XLEN] = (addr == '0) ? '0 :
                                         hit          ? wb_data :
                                                        regs[addr];
        assign rd_busy[p] = pending[addr] && !hit;
    end

    assign iss_waw   = iss_vld && pending[iss_addr] && !(wb_vld && (wb_addr == iss_addr));
    assign wb_orphan = wb_vld && (wb_addr != '0) && !pending[wb_addr];
    assign pend_cnt  = cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb; a forwarding and a
// non-forwarding instance share one stimulus stream.
module tb_reg_file_sb;

    localparam int S_RD0    = 0;
    localparam int S_RD1    = 1;
    localparam int S_BUSY0  = 2;
    localparam int S_BUSY1  = 3;
    localparam int S_WAW    = 4;
    localparam int S_ORPH   = 5;
    localparam int S_CNT    = 6;
    localparam int S_NRD0   = 7;
    localparam int S_NRD1   = 8;
    localparam int S_NBUSY0 = 9;
    localparam int S_NBUSY1 = 10;
    localparam int S_NWAW   = 11;
    localparam int S_NORPH  = 12;
    localparam int S_NCNT   = 13;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic        iss_vld;
    logic [4:0]  iss_addr;
    logic        wb_vld;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_waw;
    logic        wb_orphan;
    logic [5:0]  pend_cnt;

    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_busy;
    logic        nb_iss_waw;
    logic        nb_wb_orphan;
    logic [5:0]  nb_pend_cnt;

    typedef struct {
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    reg_file_sb #(.XLEN(32), .NUM_REGS(32), .RD_PORTS(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .iss_vld(iss_vld), .iss_addr(iss_addr),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_waw(iss_waw), .wb_orphan(wb_orphan), .pend_cnt(pend_cnt)
    );

    reg_file_sb #(.XLEN(32), .NUM_REGS(32), .RD_PORTS(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data),
        .rd_busy(nb_rd_busy), .iss_vld(iss_vld), .iss_addr(iss_addr),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_waw(nb_iss_waw), .wb_orphan(nb_wb_orphan), .pend_cnt(nb_pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_RD0:    return {32'h0, rd_data[31:0]};
            S_RD1:    return {32'h0, rd_data[63:32]};
            S_BUSY0:  return {63'h0, rd_busy[0]};
            S_BUSY1:  return {63'h0, rd_busy[1]};
            S_WAW:    return {63'h0, iss_waw};
            S_ORPH:   return {63'h0, wb_orphan};
            S_CNT:    return {58'h0, pend_cnt};
            S_NRD0:   return {32'h0, nb_rd_data[31:0]};
            S_NRD1:   return {32'h0, nb_rd_data[63:32]};
            S_NBUSY0: return {63'h0, nb_rd_busy[0]};
            S_NBUSY1: return {63'h0, nb_rd_busy[1]};
            S_NWAW:   return {63'h0, nb_iss_waw};
            S_NORPH:  return {63'h0, nb_wb_orphan};
            S_NCNT:   return {58'h0, nb_pend_cnt};
            default:  return '1;
        endcase
    endfunction

    // Inputs change on the falling edge so they are stable at the next rising edge.
    task automatic applyStimulus(input logic r, input logic iv, input logic [4:0] ia,
                                 input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        @(negedge clk);
        rst_n    = r;
        iss_vld  = iv;
        iss_addr = ia;
        wb_vld   = wv;
        wb_addr  = wa;
        wb_data  = wd;
        rd_addr  = {ra1, ra0};
    endtask

    task automatic pushExpect(input string tag, input int sel, input logic [63:0] value);
        exp_t e;
        e.sel = sel;
        e.exp = value;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t        e;
        string       tag;
        logic [63:0] obs;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; iss_vld = 1'b0; iss_addr = '0; wb_vld = 1'b0;
        wb_addr = '0; wb_data = '0; rd_addr = '0;

        // Reset for two edges, then check the cleared state.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 5, 1);
        pushExpect("rst_cnt", S_CNT, 0);
        pushExpect("rst_rd0", S_RD0, 0);
        pushExpect("rst_rd1", S_RD1, 0);
        pushExpect("rst_busy0", S_BUSY0, 0);
        checkOutput();

        // Orphan write then read back.
        applyStimulus(1, 0, 0, 1, 5, 32'hDEADBEEF, 5, 6);
        pushExpect("wr_orphan", S_ORPH, 1);
        pushExpect("wr_bypass_rd0", S_RD0, 32'hDEADBEEF);
        pushExpect("wr_nobypass_rd0", S_NRD0, 0);
        pushExpect("wr_nb_orphan", S_NORPH, 1);
        checkOutput();
        applyStimulus(1, 0, 0, 1, 3, 32'hAA, 5, 6);
        pushExpect("rdback_rd0", S_RD0, 32'hDEADBEEF);
        pushExpect("rdback_busy0", S_BUSY0, 0);
        pushExpect("rdback_nb_rd0", S_NRD0, 32'hDEADBEEF);
        pushExpect("rdback_rd1_x6", S_RD1, 0);
        pushExpect("orphan_x3", S_ORPH, 1);
        checkOutput();

        // RAW hazard on x3 and forwarding.
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 3);
        pushExpect("raw_iss_busy1", S_BUSY1, 0);
        pushExpect("raw_iss_waw", S_WAW, 0);
        pushExpect("raw_iss_cnt", S_CNT, 0);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 3);
        pushExpect("raw_busy1", S_BUSY1, 1);
        pushExpect("raw_cnt", S_CNT, 1);
        pushExpect("raw_old_rd1", S_RD1, 32'hAA);
        checkOutput();
        applyStimulus(1, 0, 0, 1, 3, 32'h12, 0, 3);
        pushExpect("byp_rd1", S_RD1, 32'h12);
        pushExpect("byp_busy1", S_BUSY1, 0);
        pushExpect("nobyp_rd1", S_NRD1, 32'hAA);
        pushExpect("nobyp_busy1", S_NBUSY1, 1);
        pushExpect("byp_orphan", S_ORPH, 0);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 3);
        pushExpect("raw_done_cnt", S_CNT, 0);
        pushExpect("raw_done_rd1", S_RD1, 32'h12);
        pushExpect("raw_done_nbusy1", S_NBUSY1, 0);
        checkOutput();

        // Same-address issue and writeback on a pending register.
        applyStimulus(1, 1, 7, 0, 0, 0, 7, 0);
        checkOutput();
        applyStimulus(1, 1, 7, 1, 7, 32'h55, 7, 0);
        pushExpect("same_waw", S_WAW, 0);
        pushExpect("same_orphan", S_ORPH, 0);
        pushExpect("same_busy0", S_BUSY0, 0);
        pushExpect("same_nbusy0", S_NBUSY0, 1);
        pushExpect("same_pre_cnt", S_CNT, 1);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 7, 0);
        pushExpect("same_cnt", S_CNT, 1);
        pushExpect("same_busy_after", S_BUSY0, 1);
        pushExpect("same_rd0", S_RD0, 32'h55);
        checkOutput();

        // Register zero is inert.
        applyStimulus(1, 1, 0, 1, 0, 32'hFFFF, 0, 0);
        pushExpect("x0_rd0", S_RD0, 0);
        pushExpect("x0_busy0", S_BUSY0, 0);
        pushExpect("x0_waw", S_WAW, 0);
        pushExpect("x0_orphan", S_ORPH, 0);
        pushExpect("x0_nrd0", S_NRD0, 0);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        pushExpect("x0_cnt", S_CNT, 1);
        pushExpect("x0_rd1", S_RD1, 0);
        pushExpect("x0_busy1", S_BUSY1, 0);
        checkOutput();

        // Issue and writeback on different addresses in one edge.
        applyStimulus(1, 1, 9, 1, 7, 32'h66, 9, 7);
        pushExpect("diff_orphan", S_ORPH, 0);
        pushExpect("diff_waw", S_WAW, 0);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 9, 7);
        pushExpect("diff_cnt", S_CNT, 1);
        pushExpect("diff_busy9", S_BUSY0, 1);
        pushExpect("diff_busy7", S_BUSY1, 0);
        pushExpect("diff_rd7", S_RD1, 32'h66);
        checkOutput();
        applyStimulus(1, 0, 0, 1, 9, 32'h99, 9, 0);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 9, 0);
        pushExpect("clr_cnt", S_CNT, 0);
        pushExpect("clr_rd9", S_RD0, 32'h99);
        checkOutput();

        // Fill the scoreboard x1..x31.
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1, 1, 5'(i), 0, 0, 0, 5'(i), 0);
            pushExpect("ramp_cnt", S_CNT, 64'(i - 1));
            pushExpect("ramp_waw", S_WAW, 0);
            pushExpect("ramp_busy", S_BUSY0, 0);
            checkOutput();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 4, 31);
        pushExpect("full_cnt", S_CNT, 31);
        pushExpect("full_busy4", S_BUSY0, 1);
        pushExpect("full_busy31", S_BUSY1, 1);
        checkOutput();
        applyStimulus(1, 1, 4, 0, 0, 0, 4, 0);
        pushExpect("waw_flag", S_WAW, 1);
        pushExpect("waw_nflag", S_NWAW, 1);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 4, 0);
        pushExpect("waw_cnt", S_CNT, 31);
        pushExpect("waw_ncnt", S_NCNT, 31);
        pushExpect("waw_busy4", S_BUSY0, 1);
        checkOutput();

        // Reset mid-operation with issue and writeback that must be ignored.
        applyStimulus(0, 1, 2, 1, 4, 32'h44, 5, 3);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 5, 3);
        pushExpect("mrst_cnt", S_CNT, 0);
        pushExpect("mrst_ncnt", S_NCNT, 0);
        pushExpect("mrst_rd0", S_RD0, 0);
        pushExpect("mrst_rd1", S_RD1, 0);
        pushExpect("mrst_busy0", S_BUSY0, 0);
        pushExpect("mrst_busy1", S_BUSY1, 0);
        checkOutput();
        applyStimulus(1, 0, 0, 1, 4, 32'h77, 4, 2);
        pushExpect("post_orphan", S_ORPH, 1);
        pushExpect("post_rd0", S_RD0, 32'h77);
        pushExpect("post_nrd0", S_NRD0, 0);
        pushExpect("post_busy2", S_BUSY1, 0);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 4, 0);
        pushExpect("post_rd4", S_RD0, 32'h77);
        pushExpect("post_nrd4", S_NRD0, 32'h77);
        pushExpect("post_cnt", S_CNT, 0);
        checkOutput();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
